// File: rtl/lcd_write_arbiter.sv
// Two-client arbiter for the lcd_control character-write port; also owns clearAll.
// Optional build macro LCD_ARB_TIMEOUT_EN adds a writeDone watchdog driving timeout_err.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_INIT  | lcd_control not initialised; nothing is issued
// IDLE       | choose next action: clear, locked client, or arbitration
// LOAD       | latch the granted client's byte onto dataIn
// START      | one-cycle writeStart pulse
// WAIT_DONE  | wait for the writeDone rising edge, then pulse ready
// CLEAR      | hold clearAll for CLEAR_HOLD cycles
module lcd_write_arbiter #(
  parameter int CLEAR_HOLD     = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       initDone,
  input  logic       writeDone,
  output logic       writeStart,
  output logic [7:0] dataIn,
  output logic       clearAll,
  input  logic       c0_valid,
  input  logic [7:0] c0_data,
  input  logic       c0_last,
  output logic       c0_ready,
  input  logic       c1_valid,
  input  logic [7:0] c1_data,
  input  logic       c1_last,
  output logic       c1_ready,
  input  logic       clear_req,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  localparam int CL_W = $clog2(CLEAR_HOLD + 1);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE,
    S_CLEAR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      grant_nxt;
  logic            rr;
  logic            rr_nxt;
  logic            clr_pend;
  logic [CL_W-1:0] clr_cnt;
  logic            wd_prev;
  logic            wd_edge;
  logic            enter_clear;
  logic            load_data;
  logic [1:0]      ready_vec;
  logic            timeout_hit;
  logic            gsel;
  logic            sel_valid;
  logic            sel_last;

  assign wd_edge   = writeDone & ~wd_prev;
  assign gsel      = grant[1];
  assign sel_valid = gsel ? c1_valid : c0_valid;
  assign sel_last  = gsel ? c1_last  : c0_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_WAIT_INIT;
      grant    <= 2'b00;
      rr       <= 1'b0;
      clr_pend <= 1'b0;
      clr_cnt  <= '0;
      wd_prev  <= 1'b0;
      dataIn   <= 8'h00;
      busy     <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr      <= rr_nxt;
      wd_prev <= writeDone;
      busy    <= (state_nxt != S_IDLE);
      // a request arriving on the entry cycle must survive, so set beats clear
      if (clear_req) begin
        clr_pend <= 1'b1;
      end else if (enter_clear) begin
        clr_pend <= 1'b0;
      end
      if (enter_clear) begin
        clr_cnt <= CL_W'(CLEAR_HOLD - 1);
      end else if (state == S_CLEAR && clr_cnt != '0) begin
        clr_cnt <= clr_cnt - 1'b1;
      end
      if (load_data) begin
        dataIn <= gsel ? c1_data : c0_data;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_nxt      = rr;
    enter_clear = 1'b0;
    load_data   = 1'b0;
    ready_vec   = 2'b00;
    // losing initDone aborts everything; the client re-presents its byte later
    if (state != S_WAIT_INIT && !initDone) begin
      state_nxt = S_WAIT_INIT;
      grant_nxt = 2'b00;
    end else begin
      case (state)
        S_WAIT_INIT: begin
          if (initDone) state_nxt = S_IDLE;
        end
        S_IDLE: begin
          if (|grant) begin
            if (sel_valid) state_nxt = S_LOAD;
          end else if (clr_pend) begin
            state_nxt   = S_CLEAR;
            enter_clear = 1'b1;
          end else if (c0_valid && c1_valid) begin
            grant_nxt = rr ? 2'b10 : 2'b01;
            state_nxt = S_LOAD;
          end else if (c0_valid) begin
            grant_nxt = 2'b01;
            state_nxt = S_LOAD;
          end else if (c1_valid) begin
            grant_nxt = 2'b10;
            state_nxt = S_LOAD;
          end
        end
        S_LOAD: begin
          load_data = 1'b1;
          state_nxt = S_START;
        end
        S_START: begin
          state_nxt = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (wd_edge || timeout_hit) begin
            ready_vec = grant;
            state_nxt = S_IDLE;
            // a timed-out byte is dropped and the whole message is abandoned
            if (sel_last || !wd_edge) begin
              grant_nxt = 2'b00;
              rr_nxt    = ~gsel;
            end
          end
        end
        S_CLEAR: begin
          if (clr_cnt == '0) state_nxt = S_IDLE;
        end
        default: state_nxt = S_WAIT_INIT;
      endcase
    end
  end

  assign writeStart = (state == S_START) & initDone;
  assign clearAll   = (state == S_CLEAR) & initDone;
  assign c0_ready   = ready_vec[0];
  assign c1_ready   = ready_vec[1];

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state == S_WAIT_DONE) && (to_cnt == '0) && !wd_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_START) begin
        to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
      end else if (state == S_WAIT_DONE && to_cnt != '0) begin
        to_cnt <= to_cnt - 1'b1;
      end
      if (timeout_hit && initDone) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: a per-byte vector table for arbitration,
// plus hand sequences for init, clear, initDone loss, timeout and mid-write reset.
module tb_lcd_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       initDone;
  logic       writeDone;
  logic       writeStart;
  logic [7:0] dataIn;
  logic       clearAll;
  logic       c0_valid;
  logic [7:0] c0_data;
  logic       c0_last;
  logic       c0_ready;
  logic       c1_valid;
  logic [7:0] c1_data;
  logic       c1_last;
  logic       c1_ready;
  logic       clear_req;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcd_write_arbiter #(
    .CLEAR_HOLD    (16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .initDone   (initDone),
    .writeDone  (writeDone),
    .writeStart (writeStart),
    .dataIn     (dataIn),
    .clearAll   (clearAll),
    .c0_valid   (c0_valid),
    .c0_data    (c0_data),
    .c0_last    (c0_last),
    .c0_ready   (c0_ready),
    .c1_valid   (c1_valid),
    .c1_data    (c1_data),
    .c1_last    (c1_last),
    .c1_ready   (c1_ready),
    .clear_req  (clear_req),
    .grant      (grant),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic       c0v;
    logic [7:0] c0d;
    logic       c0l;
    logic       c1v;
    logic [7:0] c1d;
    logic       c1l;
    logic [1:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic c0v, input logic [7:0] c0d, input logic c0l,
                              input logic c1v, input logic [7:0] c1d, input logic c1l,
                              input logic [1:0] eg, input logic [7:0] ed);
    vec_t v;
    v.c0v = c0v; v.c0d = c0d; v.c0l = c0l;
    v.c1v = c1v; v.c1d = c1d; v.c1l = c1l;
    v.exp_grant = eg; v.exp_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    initDone = 1'b0; writeDone = 1'b0; clear_req = 1'b0;
    c0_valid = 1'b0; c0_data = 8'h00; c0_last = 1'b0;
    c1_valid = 1'b0; c1_data = 8'h00; c1_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic raise_init();
    @(posedge clk); #1;
    initDone = 1'b1;
    @(posedge clk); #1;
  endtask

  // returns the negedge index (from 0) at which writeStart is seen, -1 if never
  task automatic wait_ws(output int lat, output int stray);
    lat = -1;
    stray = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (c0_ready || c1_ready) stray++;
      if (writeStart) begin
        lat = k;
        break;
      end
    end
  endtask

  // called at the writeStart negedge; returns at posedge+1 with the DUT back in IDLE
  task automatic do_write_done(input logic [1:0] exp_mask, input string name);
    @(negedge clk);
    check({name, "_ws_once"}, 32'(writeStart), 0);
    @(posedge clk); #1;
    writeDone = 1'b1;
    @(negedge clk);
    check({name, "_ready"}, 32'({c1_ready, c0_ready}), 32'(exp_mask));
    @(posedge clk); #1;
    writeDone = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    int   lat, stray, cnt, bad;

    vt[0]  = mk(1, 8'h48, 0, 1, 8'h41, 1, 2'b01, 8'h48);
    vt[1]  = mk(1, 8'h49, 1, 1, 8'h41, 1, 2'b01, 8'h49);
    vt[2]  = mk(0, 8'h00, 0, 1, 8'h41, 1, 2'b10, 8'h41);
    vt[3]  = mk(1, 8'h10, 1, 1, 8'h20, 1, 2'b01, 8'h10);
    vt[4]  = mk(1, 8'h11, 1, 1, 8'h20, 1, 2'b10, 8'h20);
    vt[5]  = mk(1, 8'h11, 1, 1, 8'h21, 1, 2'b01, 8'h11);
    vt[6]  = mk(1, 8'h12, 1, 1, 8'h21, 1, 2'b10, 8'h21);
    vt[7]  = mk(0, 8'h00, 0, 1, 8'h30, 1, 2'b10, 8'h30);
    vt[8]  = mk(0, 8'h00, 0, 1, 8'h31, 1, 2'b10, 8'h31);
    vt[9]  = mk(1, 8'h40, 0, 1, 8'h50, 1, 2'b01, 8'h40);
    vt[10] = mk(1, 8'h42, 1, 1, 8'h50, 1, 2'b01, 8'h42);
    vt[11] = mk(1, 8'h43, 1, 1, 8'h50, 1, 2'b10, 8'h50);

    // reset values, then no write while initDone is low
    rst = 1'b0;
    do_reset();
    rst = 1'b0;
    c0_valid = 1'b1; c0_data = 8'h5A; c0_last = 1'b1;
    #1;
    check("rst_ctrl_outs", 32'({writeStart, clearAll, busy, c0_ready, c1_ready, timeout_err}), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_datain", 32'(dataIn), 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (writeStart) cnt++;
    end
    check("no_ws_before_init", cnt, 0);
    check("busy_wait_init", 32'(busy), 1);
    initDone = 1'b1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (writeStart) begin
        lat = k;
        break;
      end
    end
    check("init_ws_latency", lat, 3);
    check("init_datain", 32'(dataIn), 32'h5A);
    check("init_grant", 32'(grant), 1);
    do_write_done(2'b01, "init");
    c0_valid = 1'b0;

    // arbitration table from a fresh reset (round-robin pointer at client 0)
    do_reset();
    raise_init();
    check("idle_busy", 32'(busy), 0);
    for (int i = 0; i < 12; i++) begin
      c0_valid = vt[i].c0v; c0_data = vt[i].c0d; c0_last = vt[i].c0l;
      c1_valid = vt[i].c1v; c1_data = vt[i].c1d; c1_last = vt[i].c1l;
      wait_ws(lat, stray);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_stray_ready", i), stray, 0);
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].exp_grant));
      check($sformatf("vec%0d_datain", i), 32'(dataIn), 32'(vt[i].exp_data));
      do_write_done(vt[i].exp_grant, $sformatf("vec%0d", i));
    end
    c0_valid = 1'b0;
    c1_valid = 1'b0;

    // clear requested mid-message waits for c1's last byte
    c1_valid = 1'b1; c1_data = 8'h60; c1_last = 1'b0;
    wait_ws(lat, stray);
    check("clr_msg_b0_data", 32'(dataIn), 32'h60);
    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    do_write_done(2'b10, "clr_msg_b0");
    c1_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (clearAll) cnt++;
    end
    check("clr_held_off_locked", cnt, 0);
    check("clr_lock_kept", 32'(grant), 2);
    @(posedge clk); #1;
    c1_valid = 1'b1; c1_data = 8'h61; c1_last = 1'b1;
    wait_ws(lat, stray);
    check("clr_msg_b1_latency", lat, 2);
    check("clr_msg_b1_data", 32'(dataIn), 32'h61);
    do_write_done(2'b10, "clr_msg_b1");
    c1_valid = 1'b0;
    bad = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clearAll) cnt++;
      if (clearAll !== (((i >= 1) && (i <= 16)) || ((i >= 18) && (i <= 33)))) bad++;
      if (i == 5) clear_req = 1'b1;
      if (i == 6) clear_req = 1'b0;
    end
    check("clr_pattern_errors", bad, 0);
    check("clr_high_cycles", cnt, 32);

    // initDone lost during WAIT_DONE: abort without ready, byte rewritten later
    @(posedge clk); #1;
    c0_valid = 1'b1; c0_data = 8'h77; c0_last = 1'b1;
    wait_ws(lat, stray);
    check("drop_first_data", 32'(dataIn), 32'h77);
    @(posedge clk); #1;
    initDone  = 1'b0;
    writeDone = 1'b1;
    @(negedge clk);
    check("drop_no_ready", 32'({c1_ready, c0_ready}), 0);
    @(posedge clk); #1;
    writeDone = 1'b0;
    check("drop_grant", 32'(grant), 0);
    check("drop_busy", 32'(busy), 1);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (c0_ready || c1_ready || writeStart) cnt++;
    end
    check("drop_quiet", cnt, 0);
    initDone = 1'b1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (writeStart) begin
        lat = k;
        break;
      end
    end
    check("drop_rewrite_latency", lat, 3);
    check("drop_rewrite_data", 32'(dataIn), 32'h77);
    check("drop_rewrite_grant", 32'(grant), 1);
    do_write_done(2'b01, "drop_rewrite");
    c0_valid = 1'b0;

`ifdef LCD_ARB_TIMEOUT_EN
    @(posedge clk); #1;
    c0_valid = 1'b1; c0_data = 8'h88; c0_last = 1'b1;
    wait_ws(lat, stray);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (c0_ready) begin
        lat = k;
        break;
      end
    end
    check("to_ready_cycle", lat, 100);
    @(posedge clk); #1;
    c0_valid = 1'b0;
    check("to_err", 32'(timeout_err), 1);
    check("to_busy", 32'(busy), 0);
    check("to_grant", 32'(grant), 0);
`else
    check("to_err_tied", 32'(timeout_err), 0);
`endif

    // reset asserted while a write is in flight
    @(posedge clk); #1;
    c1_valid = 1'b1; c1_data = 8'h99; c1_last = 1'b1;
    wait_ws(lat, stray);
    check("midrst_ws", 32'(writeStart), 1);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_outs", 32'({writeStart, clearAll, busy, c0_ready, c1_ready}), 0);
    check("midrst_grant", 32'(grant), 0);
    check("midrst_datain", 32'(dataIn), 0);
    c1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
